// File: rtl/wb_sequencer.sv
// Write-back sequencer: accepts one decoded instruction at a time, waits for
// load data when needed and issues a single register-file write per instruction.
module wb_sequencer #(
    parameter int unsigned LOAD_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [6:0] opcode,
    input  logic [4:0] rd,
    input  logic       mem_ready,
    output logic [1:0] wb_sel,
    output logic       reg_write,
    output logic [4:0] rd_out,
    output logic       stall,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, EXEC, LOAD_WAIT, WB} state_t;
    typedef enum logic [2:0] {C_ALU, C_LOAD, C_LINK, C_AUIPC, C_NOWB, C_ILLEGAL} cls_t;

    localparam logic [7:0] WAIT_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d, dec_cls;
    logic [1:0] sel_q, sel_d, dec_sel;
    logic [4:0] rd_q, rd_d;
    logic [7:0] cnt_q, cnt_d;
    logic       instr_ready_q, instr_ready_d;
    logic       stall_q, stall_d;
    logic       reg_write_q, reg_write_d;
    logic [1:0] wb_sel_q, wb_sel_d;
    logic [4:0] rd_out_q, rd_out_d;
    logic       err_q, err_d;

    always_comb begin
        dec_cls = C_ILLEGAL;
        dec_sel = 2'b00;
        case (opcode)
            7'b0110011, 7'b0010011, 7'b0110111: dec_cls = C_ALU;
            7'b0000011:                         dec_cls = C_LOAD;
            7'b1101111, 7'b1100111: begin
                dec_cls = C_LINK;
                dec_sel = 2'b01;
            end
            7'b0010111: begin
                dec_cls = C_AUIPC;
                dec_sel = 2'b10;
            end
            7'b0100011, 7'b1100011:             dec_cls = C_NOWB;
            default:                            dec_cls = C_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        sel_d   = sel_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    state_d = EXEC;
                    cls_d   = dec_cls;
                    sel_d   = dec_sel;
                    rd_d    = rd;
                end
            end
            EXEC: begin
                case (cls_q)
                    C_ALU, C_LINK, C_AUIPC: state_d = WB;
                    C_LOAD: begin
                        state_d = LOAD_WAIT;
                        cnt_d   = 8'd0;
                    end
                    C_ILLEGAL: begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
            LOAD_WAIT: begin
                // Data arriving on the timeout edge still wins.
                if (mem_ready) begin
                    state_d = WB;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state presents.
        instr_ready_d = (state_d == IDLE);
        stall_d       = (state_d != IDLE);
        wb_sel_d      = (state_d == IDLE) ? 2'b00 : sel_d;
        rd_out_d      = (state_d == IDLE) ? 5'd0 : rd_d;
        reg_write_d   = (state_d == WB) && (rd_d != 5'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cls_q         <= C_NOWB;
            sel_q         <= 2'b00;
            rd_q          <= 5'd0;
            cnt_q         <= 8'd0;
            instr_ready_q <= 1'b1;
            stall_q       <= 1'b0;
            reg_write_q   <= 1'b0;
            wb_sel_q      <= 2'b00;
            rd_out_q      <= 5'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cls_q         <= cls_d;
            sel_q         <= sel_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
            instr_ready_q <= instr_ready_d;
            stall_q       <= stall_d;
            reg_write_q   <= reg_write_d;
            wb_sel_q      <= wb_sel_d;
            rd_out_q      <= rd_out_d;
            err_q         <= err_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign stall       = stall_q;
    assign reg_write   = reg_write_q;
    assign wb_sel      = wb_sel_q;
    assign rd_out      = rd_out_q;
    assign err         = err_q;

endmodule

// File: doc/wb_sequencer.md
WB_SEQUENCER -- requirements
Module: wb_sequencer

Interface
REQ-001 The block SHALL have parameter LOAD_TIMEOUT, default 16, meaning the maximum number of LOAD_WAIT cycles before a load is aborted; the legal range is 1..255.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single system clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide, asynchronous and active-high reset.
REQ-004 Port instr_valid SHALL be an input, 1 bit wide, indicating that a decoded instruction is offered.
REQ-005 Port instr_ready SHALL be an output, 1 bit wide, indicating that the sequencer accepts the instruction this cycle.
REQ-006 Port opcode SHALL be an input, 7 bits wide, carrying RV32I opcode field bits [6:0].
REQ-007 Port rd SHALL be an input, 5 bits wide, carrying the destination register index.
REQ-008 Port mem_ready SHALL be an input, 1 bit wide, indicating that load data is valid on the write-data mux input 00.
REQ-009 Port wb_sel SHALL be an output, 2 bits wide, driving the write-data mux select: 00 = ALU/memory data, 01 = PC+4, 10 = PC+imm.
REQ-010 Port reg_write SHALL be an output, 1 bit wide, acting as the register-file write enable.
REQ-011 Port rd_out SHALL be an output, 5 bits wide, carrying the register-file write address.
REQ-012 Port stall SHALL be an output, 1 bit wide, and freezes the PC/fetch path.
REQ-013 Port err SHALL be an output, 1 bit wide, giving a one-cycle pulse on an illegal opcode or a load timeout.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, EXEC, LOAD_WAIT and WB, and all outputs SHALL be registered.
REQ-015 The instr_ready output SHALL be 1 only in IDLE, and stall SHALL be 1 in every state except IDLE.
REQ-016 Acceptance SHALL occur at a rising edge with state IDLE and instr_valid=1, at which point opcode, rd and the decoded class are latched; instr_valid outside IDLE SHALL be ignored.
REQ-017 The decode SHALL map 0110011, 0010011 and 0110111 (LUI) to class ALU with wb_sel 00; 0000011 to class LOAD with wb_sel 00; 1101111 and 1100111 to class LINK with wb_sel 01; 0010111 to class AUIPC with wb_sel 10; 0100011 and 1100011 to class NOWB; every other opcode to class ILLEGAL.
REQ-018 The IDLE->EXEC transition SHALL be taken on acceptance, for every class.
REQ-019 From EXEC, the FSM SHALL go to WB for ALU, LINK or AUIPC; to LOAD_WAIT for LOAD; and to IDLE for NOWB or ILLEGAL, with ILLEGAL pulsing err=1 for the cycle after EXEC.
REQ-020 In LOAD_WAIT, mem_ready=1 at an edge SHALL move the FSM to WB.
REQ-021 In LOAD_WAIT, an 8-bit wait counter SHALL be cleared on entry and SHALL increment on each edge with mem_ready=0.
REQ-022 When the wait counter equals LOAD_TIMEOUT-1 and mem_ready=0, the FSM SHALL go to IDLE, pulse err for one cycle and perform no register write.
REQ-023 When mem_ready=1 on the same edge as the timeout condition, mem_ready SHALL take priority (go to WB, no err).
REQ-024 WB SHALL last exactly one cycle: reg_write=1 if the latched rd!=0, otherwise 0, and rd_out=latched rd; the FSM then returns to IDLE.
REQ-025 The wb_sel output SHALL hold the latched class select in EXEC, LOAD_WAIT and WB, and SHALL be 00 in IDLE.
REQ-026 The rd_out output SHALL hold the latched rd while not in IDLE, and SHALL be 0 in IDLE.
REQ-027 For non-load writers, acceptance at edge N SHALL produce reg_write high during the cycle after edge N+1, giving a 2-cycle accept-to-write latency.
REQ-028 For loads, mem_ready sampled at edge M SHALL produce reg_write high during the cycle after edge M.
REQ-029 The reg_write output SHALL never be high outside WB, and SHALL assert at most once per accepted instruction.
REQ-030 The err output SHALL never be high simultaneously with reg_write.

Reset
REQ-031 Assertion of rst SHALL immediately force state IDLE, wait counter 0, instr_ready=1, stall=0, reg_write=0, wb_sel=00, rd_out=0 and err=0.
REQ-032 A reset asserted mid-operation (EXEC, LOAD_WAIT or WB) SHALL abandon the instruction without a register write.
REQ-033 After rst deasserts, the first rising edge SHALL be able to accept an instruction.

Verification
REQ-034 The bench SHALL apply opcode 0110011 with rd=5 accepted at edge 0 and SHALL check reg_write=1, wb_sel=00 and rd_out=5 during cycle 2 only, with stall=1 during cycles 1-2.
REQ-035 The bench SHALL apply opcode 1101111 with rd=1, then 0010111 with rd=7, and SHALL check wb_sel=01 and 10 respectively at the write cycle.
REQ-036 The bench SHALL apply opcode 0000011 with rd=3 and mem_ready raised after 5 LOAD_WAIT cycles, and SHALL check a single reg_write with wb_sel=00 and rd_out=3 one cycle later.
REQ-037 The bench SHALL run a load with mem_ready held 0 and LOAD_TIMEOUT=4, and SHALL check an err pulse after 4 LOAD_WAIT cycles, no reg_write, and return to IDLE; a repeat with mem_ready=1 on the 4th cycle SHALL write with no err.
REQ-038 The bench SHALL apply opcode 1111111, then 0100011, then 0110011 with rd=0, and SHALL check err pulsed only for the first and reg_write=0 for all three.
REQ-039 The bench SHALL assert rst during LOAD_WAIT and SHALL check that all outputs immediately take their reset values and no write occurs after release.
